ps2_kbd_ctrl: RTL and testbench
===============================

Name: ps2_kbd_ctrl

Overview:
Sequencer and decoder sitting directly behind the PS/2 receiver.
- Drives the receiver's rx_en and consumes its rx_done_tick and 8-bit data.
- Assembles multi-byte scan-code sequences (E0 extended prefix, F0 break prefix) into single key events.
- Buffers events in a small FIFO read by downstream logic, and applies backpressure by deasserting rx_en when the FIFO is full.

Parameters:
- FIFO_AW, 2, log2 of event FIFO depth (depth = 2**FIFO_AW = 4).
- TIMEOUT_CYCLES, 2500000, clk cycles allowed between bytes of one sequence before it is abandoned.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  controller enable; 0 stops reception and discards any partial sequence.
- rx_done_tick  in  1  one-cycle pulse from the receiver: byte valid on rx_data.
- rx_data  in  8  received data byte.
- rx_en  out  1  receive enable to the receiver.
- ev_valid  out  1  FIFO not empty; head event is on the ev_* outputs.
- ev_code  out  8  scan code of the head event.
- ev_ext  out  1  head event was E0-prefixed.
- ev_break  out  1  head event is a key release (F0-prefixed).
- ev_rd  in  1  pop the head event; ignored when ev_valid=0.
- fifo_full  out  1  FIFO holds 2**FIFO_AW events.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- seq_timeout  out  1  sticky: a partial sequence was abandoned by timeout.
- clr_err  in  1  clears overflow and seq_timeout.

Behaviour:
Reset values:
- FSM in WAIT; FIFO empty.
- ev_valid=0, ev_code=0, ev_ext=0, ev_break=0.
- fifo_full=0, overflow=0, seq_timeout=0, rx_en=0.

rx_en:
- rx_en = enable & ~fifo_full, registered. It changes one cycle after its inputs change.

FSM states: WAIT, GOT_E0, GOT_F0. An ext_reg flag records an E0 prefix. All transitions occur only on rx_done_tick with enable=1.
- WAIT:
  - E0 -> GOT_E0, ext_reg=1.
  - F0 -> GOT_F0, ext_reg=0.
  - AA (BAT ok) or FA (ACK) -> discarded, stay in WAIT.
  - Any other byte -> push {ext=0, brk=0, code}, stay in WAIT.
- GOT_E0:
  - F0 -> GOT_F0, ext_reg kept at 1.
  - E0 -> stay in GOT_E0.
  - Other byte -> push {ext=1, brk=0, code} -> WAIT.
- GOT_F0:
  - Any byte -> push {ext=ext_reg, brk=1, code} -> WAIT, ext_reg=0.

Timeout:
- Counter clears on every accepted byte and counts while in GOT_E0 or GOT_F0.
- When it reaches TIMEOUT_CYCLES-1: -> WAIT, ext_reg=0, seq_timeout set.
- Counter width is clog2(TIMEOUT_CYCLES).

Event timing:
- A pushed event is visible on ev_valid/ev_* in the cycle after rx_done_tick (1-cycle latency).

FIFO:
- First-word-fall-through; 10-bit entries {ext, brk, code}.
- Push while full: event dropped, overflow set.
- Push and pop in the same cycle while full: pop takes effect first, push accepted, fifo_full stays 1.
- Push and pop in the same cycle while empty: the event is written; ev_valid rises the next cycle.
- Pointers wrap modulo depth; a separate count of width FIFO_AW+1 distinguishes full from empty.

enable:
- enable=0 forces the FSM to WAIT next cycle, clears ext_reg and the timeout counter, and discards any rx_done_tick.
- The FIFO contents and the reads are unaffected.

Sticky flags:
- clr_err has priority below set: if a set and clr_err coincide, the flag stays 1.

Reset mid-sequence:
- Returns everything to the reset values immediately (asynchronous).

Decomposition:
- Package ps2_kbd_pkg holds:
  - the byte constants PREFIX_EXT=8'hE0, PREFIX_BRK=8'hF0, CODE_BAT=8'hAA, CODE_ACK=8'hFA;
  - the FSM state encoding (2 bits);
  - EV_W=10 and the field positions of ext, brk and code within an event.
- One sub-module, ps2_event_fifo, is parameterised by FIFO_AW. Its ports are clk, reset, wr, wdata[9:0], rd, rdata[9:0], empty, full.
- The controller itself holds the FSM, the timeout counter and the sticky flags.

Test Plan (TIMEOUT_CYCLES=100, FIFO_AW=2):
- Ticks 1C; F0,1C (no reads) -> events {0,0,1C} then {0,1,1C}; each ev_valid rises 1 cycle after its tick; rx_en stays 1.
- Ticks E0,75; E0,F0,75 -> events {1,0,75} and {1,1,75}; AA and FA ticks produce no events.
- Five plain codes 01..05 with no reads -> after 4 pushes fifo_full=1, rx_en=0 next cycle; forced 5th tick sets overflow=1; four pops return 01..04; clr_err clears overflow.
- With 4 events queued, ev_rd and a new tick in the same cycle -> the pop succeeds, the new code is accepted, overflow stays 0, and the FIFO order is preserved.
- Tick E0, then 100 idle cycles -> seq_timeout=1 and the FSM is in WAIT; a following 1C gives {0,0,1C}, not extended.
- Tick F0, drop enable for 1 cycle, then tick 1C with enable=1 -> event {0,0,1C}.
- Tick F0, assert reset, then tick 1C -> event {0,0,1C}; every output held at its reset value while reset was high.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard scan-code controller.
// Holds the protocol byte values, the sequencer state encoding and the
// layout of one queued key event {ext, brk, code}.
package ps2_kbd_pkg;

    // Protocol bytes seen from the keyboard
    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;
    localparam logic [7:0] CODE_BAT   = 8'hAA;
    localparam logic [7:0] CODE_ACK   = 8'hFA;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_GOT_E0 = 2'd1,
        ST_GOT_F0 = 2'd2
    } state_t;

    // Event word layout
    localparam int EV_W        = 10;
    localparam int EV_EXT_BIT  = 9;
    localparam int EV_BRK_BIT  = 8;
    localparam int EV_CODE_LSB = 0;
    localparam int EV_CODE_W   = 8;

    function automatic logic [EV_W-1:0] pack_ev(input logic ext, input logic brk,
                                               input logic [EV_CODE_W-1:0] code);
        logic [EV_W-1:0] ev;
        ev = '0;
        ev[EV_EXT_BIT] = ext;
        ev[EV_BRK_BIT] = brk;
        ev[EV_CODE_LSB +: EV_CODE_W] = code;
        return ev;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO, depth 2**FIFO_AW, EV_W-bit entries.
// Ports: clk/reset (async, active-high); wr/wdata push; rd pops the head on rdata;
// empty/full status. A read while full frees a slot for a same-cycle write.
module ps2_event_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic [EV_W-1:0] wdata,
    input  logic            rd,
    output logic [EV_W-1:0] rdata,
    output logic            empty,
    output logic            full
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);

    logic [EV_W-1:0]    mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               do_rd, do_wr;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        // Pop is resolved first so a full FIFO can still take a write this cycle.
        do_rd    = rd & ~empty;
        do_wr    = wr & (~full | do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only observable after it is written.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into single key events queued in a FIFO.
// Ports: clk/reset (async, active-high); enable; receiver handshake rx_en/rx_done_tick/rx_data;
// event read side ev_valid/ev_code/ev_ext/ev_break/ev_rd; status fifo_full/overflow/seq_timeout; clr_err.
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_AW        = 2,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    input  logic       ev_rd,
    output logic       fifo_full,
    output logic       overflow,
    output logic       seq_timeout,
    input  logic       clr_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t          state_q, state_d;
    logic            ext_q, ext_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            overflow_q, overflow_d;
    logic            seq_timeout_q, seq_timeout_d;
    logic            rx_en_q, rx_en_d;

    logic            push_vld;
    logic [EV_W-1:0] push_dat;
    logic            tmo_set;
    logic            ovf_set;
    logic [EV_W-1:0] fifo_rdata;
    logic            fifo_empty;

    ps2_event_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (push_vld),
        .wdata (push_dat),
        .rd    (ev_rd),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_d  = state_q;
        ext_d    = ext_q;
        cnt_d    = cnt_q;
        push_vld = 1'b0;
        push_dat = '0;
        tmo_set  = 1'b0;
        if (!enable) begin
            state_d = ST_WAIT;
            ext_d   = 1'b0;
            cnt_d   = '0;
        end else if (rx_done_tick) begin
            cnt_d = '0;
            case (state_q)
                ST_GOT_E0: begin
                    if (rx_data == PREFIX_BRK) begin
                        state_d = ST_GOT_F0;
                    end else if (rx_data != PREFIX_EXT) begin
                        push_vld = 1'b1;
                        push_dat = pack_ev(1'b1, 1'b0, rx_data);
                        state_d  = ST_WAIT;
                        ext_d    = 1'b0;
                    end
                end
                ST_GOT_F0: begin
                    push_vld = 1'b1;
                    push_dat = pack_ev(ext_q, 1'b1, rx_data);
                    state_d  = ST_WAIT;
                    ext_d    = 1'b0;
                end
                default: begin
                    if (rx_data == PREFIX_EXT) begin
                        state_d = ST_GOT_E0;
                        ext_d   = 1'b1;
                    end else if (rx_data == PREFIX_BRK) begin
                        state_d = ST_GOT_F0;
                        ext_d   = 1'b0;
                    end else if (rx_data != CODE_BAT && rx_data != CODE_ACK) begin
                        push_vld = 1'b1;
                        push_dat = pack_ev(1'b0, 1'b0, rx_data);
                    end
                end
            endcase
        end else if (state_q != ST_WAIT) begin
            // Inter-byte gap inside a prefix sequence: abandon it once the gap is too long.
            if (cnt_q == CNT_MAX) begin
                state_d = ST_WAIT;
                ext_d   = 1'b0;
                cnt_d   = '0;
                tmo_set = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = '0;
        end

        // A pop in the same cycle makes room, so only an unpopped full FIFO drops.
        ovf_set = push_vld & fifo_full & ~ev_rd;

        overflow_d = overflow_q;
        if (clr_err) overflow_d = 1'b0;
        if (ovf_set) overflow_d = 1'b1;

        seq_timeout_d = seq_timeout_q;
        if (clr_err) seq_timeout_d = 1'b0;
        if (tmo_set) seq_timeout_d = 1'b1;

        rx_en_d = enable & ~fifo_full;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_WAIT;
            ext_q         <= 1'b0;
            cnt_q         <= '0;
            overflow_q    <= 1'b0;
            seq_timeout_q <= 1'b0;
            rx_en_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ext_q         <= ext_d;
            cnt_q         <= cnt_d;
            overflow_q    <= overflow_d;
            seq_timeout_q <= seq_timeout_d;
            rx_en_q       <= rx_en_d;
        end
    end

    // Head fields are forced to zero while the FIFO is empty so stale entries never show.
    assign ev_valid    = ~fifo_empty;
    assign ev_code     = fifo_empty ? 8'h00 : fifo_rdata[EV_CODE_LSB +: EV_CODE_W];
    assign ev_ext      = ~fifo_empty & fifo_rdata[EV_EXT_BIT];
    assign ev_break    = ~fifo_empty & fifo_rdata[EV_BRK_BIT];
    assign overflow    = overflow_q;
    assign seq_timeout = seq_timeout_q;
    assign rx_en       = rx_en_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
module tb_ps2_kbd_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ev_rd;
    logic       fifo_full;
    logic       overflow;
    logic       seq_timeout;
    logic       clr_err;

    ps2_kbd_ctrl #(.FIFO_AW(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rx_en        (rx_en),
        .ev_valid     (ev_valid),
        .ev_code      (ev_code),
        .ev_ext       (ev_ext),
        .ev_break     (ev_break),
        .ev_rd        (ev_rd),
        .fifo_full    (fifo_full),
        .overflow     (overflow),
        .seq_timeout  (seq_timeout),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: event queue plus the bytes of the unfinished sequence.
    logic [9:0] mq[$];
    logic [7:0] pend[$];
    int         idle;
    logic       m_ovf, m_tmo, m_rxen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] head();
        return {ev_ext, ev_break, ev_code};
    endfunction

    task automatic model_reset();
        mq.delete();
        pend.delete();
        idle   = 0;
        m_ovf  = 1'b0;
        m_tmo  = 1'b0;
        m_rxen = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic tk, input logic [7:0] dat,
                              input logic rd, input logic clr);
        logic       have_ev;
        logic [9:0] ev;
        logic       ovf_set, tmo_set;
        have_ev = 1'b0;
        ev      = '0;
        ovf_set = 1'b0;
        tmo_set = 1'b0;
        m_rxen  = en && (mq.size() != DEPTH);
        if (!en) begin
            pend.delete();
            idle = 0;
        end else if (tk) begin
            idle = 0;
            if (pend.size() == 0) begin
                if (dat == 8'hE0 || dat == 8'hF0) pend.push_back(dat);
                else if (dat != 8'hAA && dat != 8'hFA) begin
                    ev = {2'b00, dat};
                    have_ev = 1'b1;
                end
            end else if (pend[pend.size()-1] == 8'hF0) begin
                ev = {(pend[0] == 8'hE0), 1'b1, dat};
                have_ev = 1'b1;
                pend.delete();
            end else if (dat == 8'hE0 || dat == 8'hF0) begin
                pend.push_back(dat);
            end else begin
                ev = {2'b10, dat};
                have_ev = 1'b1;
                pend.delete();
            end
        end else if (pend.size() != 0) begin
            idle++;
            if (idle >= TMO) begin
                pend.delete();
                idle = 0;
                tmo_set = 1'b1;
            end
        end
        if (rd && mq.size() != 0) void'(mq.pop_front());
        if (have_ev) begin
            if (mq.size() < DEPTH) mq.push_back(ev);
            else ovf_set = 1'b1;
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (tmo_set) m_tmo = 1'b1;
        else if (clr) m_tmo = 1'b0;
    endtask

    task automatic compare_all();
        chk("ev_valid", 32'(ev_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("ev_head", 32'(head()), 32'(mq[0]));
        chk("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("seq_timeout", 32'(seq_timeout), 32'(m_tmo));
        chk("rx_en", 32'(rx_en), 32'(m_rxen));
    endtask

    task automatic cycle(input logic en, input logic tk, input logic [7:0] dat,
                         input logic rd, input logic clr);
        enable       = en;
        rx_done_tick = tk;
        rx_data      = dat;
        ev_rd        = rd;
        clr_err      = clr;
        @(posedge clk);
        model_step(en, tk, dat, rd, clr);
        #1;
        compare_all();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ev_valid"}, 32'(ev_valid), 32'd0);
        chk({tag, "_ev_head"}, 32'(head()), 32'd0);
        chk({tag, "_fifo_full"}, 32'(fifo_full), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_seq_timeout"}, 32'(seq_timeout), 32'd0);
        chk({tag, "_rx_en"}, 32'(rx_en), 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] exp_codes [4];
        model_reset();
        reset = 1'b1;
        enable = 1'b0;
        rx_done_tick = 1'b0;
        rx_data = 8'h00;
        ev_rd = 1'b0;
        clr_err = 1'b0;
        #1 chk_reset_vals("rst0");
        enable = 1'b1;
        @(posedge clk); #1 chk_reset_vals("rst1");
        reset = 1'b0;

        // Plain make / break of 1C
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rx_en_up", 32'(rx_en), 32'd1);
        cycle(1'b1, 1'b1, 8'h1C, 1'b0, 1'b0);
        chk("make_1c_lat", 32'(ev_valid), 32'd1);
        chk("make_1c", 32'(head()), 32'h01C);
        cycle(1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h1C, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("break_1c", 32'(head()), 32'h11C);
        chk("rx_en_stays", 32'(rx_en), 32'd1);
        drain();

        // Extended make / break, BAT and ACK dropped
        cycle(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'hFA, 1'b0, 1'b0);
        chk("bat_ack_none", 32'(ev_valid), 32'd0);
        cycle(1'b1, 1'b1, 8'hE0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h75, 1'b0, 1'b0);
        chk("ext_make", 32'(head()), 32'h275);
        cycle(1'b1, 1'b1, 8'hE0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h75, 1'b0, 1'b0);
        chk("ext_break", 32'(head()), 32'h375);
        drain();

        // Fill, overflow, ordered pops, clear
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
        chk("full_after4", 32'(fifo_full), 32'd1);
        cycle(1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
        chk("rx_en_backp", 32'(rx_en), 32'd0);
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("pop_order", 32'(head()), 32'(i));
            cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Push and pop together while full
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'(8'h0A + i), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);
        chk("pp_full_ovf", 32'(overflow), 32'd0);
        chk("pp_full_full", 32'(fifo_full), 32'd1);
        exp_codes = '{8'h0B, 8'h0C, 8'h0D, 8'h0E};
        for (int i = 0; i < 4; i++) begin
            chk("pp_order", 32'(head()), 32'(exp_codes[i]));
            cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Sequence timeout
        cycle(1'b1, 1'b1, 8'hE0, 1'b0, 1'b0);
        for (int i = 0; i < TMO - 1; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("tmo_not_yet", 32'(seq_timeout), 32'd0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("tmo_set", 32'(seq_timeout), 32'd1);
        cycle(1'b1, 1'b1, 8'h1C, 1'b0, 1'b0);
        chk("tmo_after", 32'(head()), 32'h01C);
        cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("tmo_clr", 32'(seq_timeout), 32'd0);

        // Enable drop abandons the break prefix
        cycle(1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h1C, 1'b0, 1'b0);
        chk("en_drop", 32'(head()), 32'h01C);
        drain();

        // Reset in the middle of a sequence
        cycle(1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        rx_done_tick = 1'b0;
        #2 reset = 1'b1;
        #1 chk_reset_vals("rst_async");
        @(posedge clk); #1 chk_reset_vals("rst_hold");
        model_reset();
        reset = 1'b0;
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h1C, 1'b0, 1'b0);
        chk("rst_mid", 32'(head()), 32'h01C);
        drain();

        // Randomized traffic; sparse ticks near the end let sequences time out
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] b;
            int         r;
            logic       tk;
            r = int'($urandom_range(0, 9));
            if (r < 2) b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else if (r == 4) b = 8'hAA;
            else if (r == 5) b = 8'hFA;
            else b = 8'($urandom_range(0, 255));
            tk = ($urandom_range(0, 99) < ((i < 2500) ? 30 : 2));
            cycle($urandom_range(0, 19) != 0, tk, b, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 29) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
